// File: rtl/image_pkg.sv
// Shared image-RAM definitions used by the arbiter, drawing grid and NN core.
package image_pkg;

    localparam int GRID_SIZE = 28;
    localparam int IMG_DEPTH = GRID_SIZE * GRID_SIZE;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DRAW = 2'd1,
        OWN_DISP = 2'd2,
        OWN_NN   = 2'd3
    } owner_t;

    // Travels with each access through the read-return pipeline.
    typedef struct packed {
        owner_t owner;
        logic   oor;
    } read_tag_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clear_state_t;

endpackage

// File: rtl/image_clear_engine.sv
// Walks every image address once, writing zeros; ignores new requests until finished.
//   state    | meaning
//   ST_IDLE  | RAM free for requesters, counter parked at 0
//   ST_CLEAR | counter address is written with 0 this cycle, counter advances
module image_clear_engine
    import image_pkg::*;
#(
    parameter int DEPTH  = IMG_DEPTH,
    parameter int ADDR_W = 16
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [ADDR_W-1:0] clear_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clear_state_t      state_q;
    clear_state_t      state_d;
    logic [ADDR_W-1:0] count_q;
    logic              last_word;

    assign last_word = (count_q == LAST_ADDR);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (clear_req) state_d = ST_CLEAR;
            ST_CLEAR: if (last_word) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Holding the counter at 0 in IDLE makes the first CLEAR cycle start at address 0.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            count_q    <= '0;
            clear_done <= 1'b0;
        end else begin
            clear_done <= (state_q == ST_CLEAR) && last_word;
            if (state_q == ST_CLEAR) begin
                count_q <= count_q + ADDR_W'(1);
            end else begin
                count_q <= '0;
            end
        end
    end

    assign clear_busy = (state_q == ST_CLEAR);
    assign clear_addr = count_q;

endmodule

// File: rtl/image_ram_arbiter.sv
// Single-port image RAM arbiter: draw writer, display and NN readers, plus the clear engine.
// Draw has priority; the two readers alternate when both request.
module image_ram_arbiter
    import image_pkg::*;
#(
    parameter int DEPTH       = IMG_DEPTH,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_data,
    output logic              draw_ack,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              nn_req,
    input  logic [ADDR_W-1:0] nn_addr,
    output logic              nn_ack,
    output logic              nn_valid,
    output logic [DATA_W-1:0] nn_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    logic [ADDR_W-1:0] clear_addr;
    logic              avail;
    logic              rd_avail;
    logic              rr_last_disp;
    read_tag_t         tag_in;
    read_tag_t         tag_q [RAM_LATENCY+1];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] nn_hold;
    logic [DATA_W-1:0] disp_hold;

    image_clear_engine #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .clear_addr (clear_addr)
    );

    // The done cycle still carries the last clear write on the RAM pins.
    assign avail    = !reset && !clear_busy && !clear_done;
    assign rd_avail = avail && !draw_req;
    assign draw_ack = avail && draw_req;
    assign nn_ack   = rd_avail && nn_req && (!disp_req || rr_last_disp);
    assign disp_ack = rd_avail && disp_req && (!nn_req || !rr_last_disp);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            rr_last_disp <= 1'b1;
        end else if (nn_ack) begin
            rr_last_disp <= 1'b0;
        end else if (disp_ack) begin
            rr_last_disp <= 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we    <= 1'b0;
        end else if (clear_busy) begin
            ram_addr  <= clear_addr;
            ram_wdata <= '0;
            ram_we    <= 1'b1;
        end else if (draw_ack) begin
            ram_addr  <= draw_addr;
            ram_wdata <= draw_data;
            ram_we    <= (draw_addr < DEPTH_A);
        end else if (nn_ack) begin
            ram_addr <= nn_addr;
            ram_we   <= 1'b0;
        end else if (disp_ack) begin
            ram_addr <= disp_addr;
            ram_we   <= 1'b0;
        end else begin
            ram_we <= 1'b0;
        end
    end

    always_comb begin
        tag_in.owner = OWN_NONE;
        tag_in.oor   = 1'b0;
        if (draw_ack) begin
            tag_in.owner = OWN_DRAW;
            tag_in.oor   = (draw_addr >= DEPTH_A);
        end else if (nn_ack) begin
            tag_in.owner = OWN_NN;
            tag_in.oor   = (nn_addr >= DEPTH_A);
        end else if (disp_ack) begin
            tag_in.owner = OWN_DISP;
            tag_in.oor   = (disp_addr >= DEPTH_A);
        end
    end

    // Stage k is visible k+1 cycles after the ack; the last stage lines up with ram_rdata.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i <= RAM_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int i = 1; i <= RAM_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign rd_word    = tag_q[RAM_LATENCY].oor ? '0 : ram_rdata;
    assign nn_valid   = (tag_q[RAM_LATENCY].owner == OWN_NN);
    assign disp_valid = (tag_q[RAM_LATENCY].owner == OWN_DISP);
    assign nn_data    = nn_valid ? rd_word : nn_hold;
    assign disp_data  = disp_valid ? rd_word : disp_hold;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            nn_hold   <= '0;
            disp_hold <= '0;
        end else begin
            if (nn_valid) nn_hold <= rd_word;
            if (disp_valid) disp_hold <= rd_word;
        end
    end

endmodule
